fc_neuron_array: RTL and testbench
==================================

Name: fc_neuron_array

Overview:
Parametrised successor to the single fully-connected neuron. Computes NUM_NEURONS fixed-point weighted sums in parallel over one shared input stream of PREVIOUS_LAYER_HEIGHT words, then adds a per-neuron bias and saturates. The block owns its own sequencing FSM, weight/bias memory address counter and ready/valid handshakes, so a layer wrapper only streams data in and collects one output vector per inference.

Parameters:
WORD_SIZE, 16, signed fixed-point word width
INT_BITS, 8, integer bits incl. sign; FRAC = WORD_SIZE-INT_BITS
PREVIOUS_LAYER_HEIGHT, 4, inputs per inference (>=1)
NUM_NEURONS, 4, parallel neurons (>=1)

Ports:
clk_i  in  1  clock
reset_i  in  1  reset
data_i  in  WORD_SIZE  signed input sample
valid_i  in  1  data_i valid
ready_o  out  1  block accepts data_i
mem_addr_o  out  $clog2(PREVIOUS_LAYER_HEIGHT+1)  weight/bias memory address
weights_i  in  NUM_NEURONS*WORD_SIZE  memory read data, neuron j at [j*WORD_SIZE +: WORD_SIZE], valid 1 cycle after mem_addr_o
data_o  out  NUM_NEURONS*WORD_SIZE  result vector, same packing
valid_o  out  1  data_o valid
ready_i  in  1  downstream accepts data_o

Interface is decided: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (async, active-high): state=ACCUM, count=0, accumulators=0, pending=0, valid_o=0, data_o=0, mem_addr_o=0, ready_o=1 after release.
- States: ACCUM, BIAS_ADDR, BIAS_ADD, DONE.
- ACCUM: ready_o=1; mem_addr_o=count. Accept = valid_i & ready_o. On accept: data_q<=data_i, pending<=1, count++. If count==PREVIOUS_LAYER_HEIGHT-1 at accept -> BIAS_ADDR.
- MAC: any cycle with pending=1: acc[j] += data_q * weights_i[j] (full 2*WORD_SIZE product, signed); pending cleared unless new accept. Gaps in valid_i are legal; no MAC without pending.
- BIAS_ADDR: ready_o=0, mem_addr_o=PREVIOUS_LAYER_HEIGHT; final MAC completes this cycle. -> BIAS_ADD.
- BIAS_ADD: sum[j] = acc[j] + (bias[j] <<< FRAC); result = sum >>> FRAC (arithmetic, truncate toward -inf); saturate to [-2^(WORD_SIZE-1), 2^(WORD_SIZE-1)-1]; register into data_o; valid_o<=1; -> DONE.
- DONE: ready_o=0; data_o, valid_o held stable until ready_i. On valid_o & ready_i: valid_o<=0, acc<=0, count<=0 -> ACCUM (ready_o high next cycle).
- Latency: valid_o rises 3 cycles after last input accept. Throughput: PREVIOUS_LAYER_HEIGHT+3 cycles per inference min.
- Accumulator width: 2*WORD_SIZE + $clog2(PREVIOUS_LAYER_HEIGHT+1) signed; no internal overflow possible.
- Reset mid-operation: all state discarded, partial sums lost, valid_o drops immediately.
- ready_i ignored outside DONE; valid_i ignored while ready_o=0.

Optional Feature:
FC_NEURON_RELU_EN: when defined, saturated result is clamped to 0 if negative (ReLU) before registering into data_o. When undefined, signed saturated result passes unchanged.

Decomposition:
- Shared package fc_pkg: FRAC_BITS function/localparam, state enum fc_state_t, saturate function (wide signed -> WORD_SIZE), ACC_WIDTH function.
- One sub-module: fc_mac_lane (one neuron: accumulator, bias align, shift, saturate, optional ReLU), instantiated NUM_NEURONS times via generate; FSM/counter stay in top.

Test Plan:
- Basic: H=4, N=4, all inputs 0x0100 (1.0), weights 0x0080 (0.5), bias 0x0100 -> every lane 0x0300, valid_o 3 cycles after last accept.
- Saturation: inputs 0x7F00, weights 0x7F00, bias 0x7F00 -> 0x7FFF; negated weights -> 0x8000 (0x0000 with FC_NEURON_RELU_EN).
- Gapped input: valid_i toggles 1-0-0-1-… -> same result as basic; mem_addr_o sequence 0,1,2,3,4 with no extra MACs.
- Backpressure: ready_i low 5 cycles in DONE -> data_o/valid_o stable, ready_o=0, valid_i ignored; release -> ready_o=1 next cycle, second inference correct (acc cleared).
- Reset mid-operation: assert reset_i after 2 accepts -> valid_o=0, mem_addr_o=0 immediately; fresh 4-input run yields basic result.
- Per-lane packing: distinct weights per neuron (lane j weight j*0x0040), inputs 1.0, bias 0 -> lane j = j*0x0100 at correct bit slice.

Source files
------------

// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fc_pkg
// Purpose  : Shared types and helpers for the fully-connected neuron array:
//            sequencing state enum, fixed-point width helpers and the
//            wide-to-word signed saturation function.
// Revision : 1.0 - initial release
// ============================================================================
package fc_pkg;

  // Sequencing states of the neuron array
  typedef enum logic [1:0] {
    ST_ACCUM     = 2'd0,
    ST_BIAS_ADDR = 2'd1,
    ST_BIAS_ADD  = 2'd2,
    ST_DONE      = 2'd3
  } fc_state_t;

  // Width of the intermediate value handed to saturate()
  localparam int SAT_WIDTH = 64;

  // Number of fractional bits of the fixed-point format
  function automatic int frac_bits(input int word_size, input int int_bits);
    return word_size - int_bits;
  endfunction

  // Accumulator width that cannot overflow for `height` full products
  function automatic int acc_width(input int word_size, input int height);
    return 2 * word_size + $clog2(height + 1);
  endfunction

  // Clamp a wide signed value into the signed range of a word_size word
  function automatic logic signed [SAT_WIDTH-1:0] saturate(
    input logic signed [SAT_WIDTH-1:0] value,
    input int                          word_size
  );
    logic signed [SAT_WIDTH-1:0] max_v;
    logic signed [SAT_WIDTH-1:0] min_v;
    logic signed [SAT_WIDTH-1:0] res;
    max_v = (64'sd1 <<< (word_size - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (word_size - 1));
    res   = value;
    if (value > max_v) begin
      res = max_v;
    end else if (value < min_v) begin
      res = min_v;
    end
    return res;
  endfunction

endpackage : fc_pkg
`default_nettype wire

// File: rtl/fc_mac_lane.sv
`default_nettype none
// ============================================================================
// Module   : fc_mac_lane
// Purpose  : One neuron of the array: signed multiply-accumulate, bias
//            alignment, arithmetic right shift back to the word format and
//            saturation into a registered result word.
//            Optional macro FC_NEURON_RELU_EN clamps negative results to 0.
// Revision : 1.0 - initial release
// ============================================================================
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int WORD_SIZE             = 16,
  parameter int INT_BITS              = 8,
  parameter int PREVIOUS_LAYER_HEIGHT = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        mac_en_i,
  input  logic                        clear_i,
  input  logic                        load_i,
  input  logic signed [WORD_SIZE-1:0] data_i,
  input  logic signed [WORD_SIZE-1:0] weight_i,
  output logic signed [WORD_SIZE-1:0] result_o
);

  localparam int FRAC  = frac_bits(WORD_SIZE, INT_BITS);
  localparam int ACC_W = acc_width(WORD_SIZE, PREVIOUS_LAYER_HEIGHT);
  // One guard bit so adding the aligned bias can never wrap
  localparam int SUM_W = ACC_W + 1;

  logic signed [ACC_W-1:0]       acc_q,    acc_d;
  logic signed [WORD_SIZE-1:0]   result_q, result_d;
  logic signed [2*WORD_SIZE-1:0] product;
  logic signed [SUM_W-1:0]       sum;
  logic signed [SUM_W-1:0]       shifted;
  logic signed [WORD_SIZE-1:0]   sat_val;

  // MAC update, bias alignment and saturation of the final result
  always_comb begin
    product = (2*WORD_SIZE)'(data_i) * (2*WORD_SIZE)'(weight_i);

    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (mac_en_i) begin
      acc_d = acc_q + ACC_W'(product);
    end

    // During the bias cycle weight_i carries the bias word
    sum     = SUM_W'(acc_q) + (SUM_W'(weight_i) <<< FRAC);
    shifted = sum >>> FRAC;
    sat_val = WORD_SIZE'(saturate(SAT_WIDTH'(shifted), WORD_SIZE));
`ifdef FC_NEURON_RELU_EN
    if (sat_val[WORD_SIZE-1]) begin
      sat_val = '0;
    end
`endif

    result_d = load_i ? sat_val : result_q;
  end

  // Accumulator and result registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;

endmodule : fc_mac_lane
`default_nettype wire

// File: rtl/fc_neuron_array.sv
`default_nettype none
// ============================================================================
// Module   : fc_neuron_array
// Purpose  : NUM_NEURONS fixed-point neurons sharing one input stream of
//            PREVIOUS_LAYER_HEIGHT words. Owns the sequencing FSM, the
//            weight/bias memory address and both ready/valid handshakes.
//            Optional macro FC_NEURON_RELU_EN enables ReLU on every lane.
// Revision : 1.0 - initial release
// ============================================================================
module fc_neuron_array
  import fc_pkg::*;
#(
  parameter int WORD_SIZE             = 16,
  parameter int INT_BITS              = 8,
  parameter int PREVIOUS_LAYER_HEIGHT = 4,
  parameter int NUM_NEURONS           = 4
) (
  input  logic                                       clk_i,
  input  logic                                       reset_i,
  input  logic [WORD_SIZE-1:0]                       data_i,
  input  logic                                       valid_i,
  output logic                                       ready_o,
  output logic [$clog2(PREVIOUS_LAYER_HEIGHT+1)-1:0] mem_addr_o,
  input  logic [NUM_NEURONS*WORD_SIZE-1:0]           weights_i,
  output logic [NUM_NEURONS*WORD_SIZE-1:0]           data_o,
  output logic                                       valid_o,
  input  logic                                       ready_i
);

  localparam int CW = $clog2(PREVIOUS_LAYER_HEIGHT + 1);

  fc_state_t             state_q,   state_d;
  logic [CW-1:0]         count_q,   count_d;
  logic [WORD_SIZE-1:0]  data_q,    data_d;
  logic                  pending_q, pending_d;
  logic                  valid_q,   valid_d;
  logic                  accept;
  logic                  clear;
  logic                  load;

  // Next-state, counter and handshake decode
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    data_d    = data_q;
    valid_d   = valid_q;
    clear     = 1'b0;
    accept    = valid_i && (state_q == ST_ACCUM);
    pending_d = accept;

    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          data_d  = data_i;
          count_d = count_q + CW'(1);
          if (count_q == CW'(PREVIOUS_LAYER_HEIGHT - 1)) begin
            state_d = ST_BIAS_ADDR;
          end
        end
      end
      // Last MAC happens here while the bias word is being fetched
      ST_BIAS_ADDR: begin
        state_d = ST_BIAS_ADD;
      end
      ST_BIAS_ADD: begin
        valid_d = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (valid_q && ready_i) begin
          valid_d = 1'b0;
          count_d = '0;
          clear   = 1'b1;
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_ACCUM;
      count_q   <= '0;
      data_q    <= '0;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      data_q    <= data_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
    end
  end

  assign load       = (state_q == ST_BIAS_ADD);
  assign ready_o    = (state_q == ST_ACCUM);
  assign mem_addr_o = (state_q == ST_ACCUM) ? count_q : CW'(PREVIOUS_LAYER_HEIGHT);
  assign valid_o    = valid_q;

  for (genvar j = 0; j < NUM_NEURONS; j++) begin : g_lane
    fc_mac_lane #(
      .WORD_SIZE             (WORD_SIZE),
      .INT_BITS              (INT_BITS),
      .PREVIOUS_LAYER_HEIGHT (PREVIOUS_LAYER_HEIGHT)
    ) u_lane (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .mac_en_i (pending_q),
      .clear_i  (clear),
      .load_i   (load),
      .data_i   (data_q),
      .weight_i (weights_i[j*WORD_SIZE +: WORD_SIZE]),
      .result_o (data_o[j*WORD_SIZE +: WORD_SIZE])
    );
  end

endmodule : fc_neuron_array
`default_nettype wire

// File: tb/tb_fc_neuron_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_neuron_array
// Purpose  : Self-checking bench for fc_neuron_array (H=4, N=4, Q8.8).
//            Honours FC_NEURON_RELU_EN when computing expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fc_neuron_array;

  localparam int W = 16;
  localparam int H = 4;
  localparam int N = 4;

  typedef logic [H-1:0][W-1:0]     xvec_t;
  typedef logic [N-1:0][W-1:0]     lane_t;
  typedef logic [H:0][N-1:0][W-1:0] mem_t;   // rows 0..H-1 weights, row H bias

  typedef struct {
    string name;
    xvec_t x;
    mem_t  mem;
    int    gap;
    lane_t exp;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset_i;
  logic [W-1:0]   data_i;
  logic           valid_i;
  logic           ready_o;
  logic [2:0]     mem_addr_o;
  logic [N*W-1:0] weights_i;
  logic [N*W-1:0] data_o;
  logic           valid_o;
  logic           ready_i;

  mem_t mem_cur;
  int   n_checks = 0;
  int   n_fail   = 0;

  fc_neuron_array #(
    .WORD_SIZE(W), .INT_BITS(8), .PREVIOUS_LAYER_HEIGHT(H), .NUM_NEURONS(N)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .mem_addr_o(mem_addr_o), .weights_i(weights_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  // Synchronous-read weight/bias memory: one cycle of latency
  always @(posedge clk) begin
    if (mem_addr_o <= 3'(H)) weights_i <= mem_cur[mem_addr_o];
    else                     weights_i <= '0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference neuron: exact integer arithmetic, floor division, clamp
  function automatic logic [W-1:0] ref_lane(input xvec_t x, input mem_t m, input int j);
    longint acc;
    longint res;
    acc = 0;
    for (int i = 0; i < H; i++)
      acc += longint'($signed(x[i])) * longint'($signed(m[i][j]));
    acc += longint'($signed(m[H][j])) * 256;
    res = acc >>> 8;
    if (res > 32767)  res = 32767;
    if (res < -32768) res = -32768;
`ifdef FC_NEURON_RELU_EN
    if (res < 0) res = 0;
`endif
    return 16'(res);
  endfunction

  // Stream H inputs with `gap` idle cycles between accepts; return result and latency
  task automatic run(input xvec_t x, input int gap, output lane_t res, output int lat);
    for (int i = 0; i < H; i++) begin
      if (i != 0) begin
        for (int g = 0; g < gap; g++) begin
          valid_i = 1'b0;
          data_i  = 16'hDEAD;
          check("addr_gap", 64'(mem_addr_o), 64'(i));
          @(posedge clk); @(negedge clk);
        end
      end
      data_i  = x[i];
      valid_i = 1'b1;
      check("addr_accept", 64'(mem_addr_o), 64'(i));
      check("ready_accum", 64'(ready_o), 64'd1);
      @(posedge clk); @(negedge clk);
    end
    valid_i = 1'b0;
    check("addr_bias", 64'(mem_addr_o), 64'(H));
    lat = 1;
    while (!valid_o && lat < 10) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'd3);
    res = data_o;
  endtask

  task automatic ack();
    ready_i = 1'b1;
    @(posedge clk); @(negedge clk);
    ready_i = 1'b0;
    check("valid_after_ack", 64'(valid_o), 64'd0);
    check("ready_after_ack", 64'(ready_o), 64'd1);
  endtask

  function automatic mem_t uniform_mem(input logic [W-1:0] w, input logic [W-1:0] b);
    mem_t m;
    for (int a = 0; a < H; a++)
      for (int j = 0; j < N; j++) m[a][j] = w;
    for (int j = 0; j < N; j++) m[H][j] = b;
    return m;
  endfunction

  function automatic xvec_t uniform_x(input logic [W-1:0] v);
    xvec_t x;
    for (int i = 0; i < H; i++) x[i] = v;
    return x;
  endfunction

  function automatic lane_t uniform_lane(input logic [W-1:0] v);
    lane_t l;
    for (int j = 0; j < N; j++) l[j] = v;
    return l;
  endfunction

  vec_t  tbl[6];
  lane_t res;
  lane_t held;
  int    lat;
  xvec_t rx;
  mem_t  rm;
  int    rgap;

  initial begin
    // ---------------- vector table ----------------
    tbl[0] = '{"basic", uniform_x(16'h0100), uniform_mem(16'h0080, 16'h0100), 0,
               uniform_lane(16'h0300)};
    tbl[1] = '{"sat_pos", uniform_x(16'h7F00), uniform_mem(16'h7F00, 16'h7F00), 0,
               uniform_lane(16'h7FFF)};
`ifdef FC_NEURON_RELU_EN
    tbl[2] = '{"sat_neg", uniform_x(16'h7F00), uniform_mem(16'h8100, 16'h7F00), 0,
               uniform_lane(16'h0000)};
`else
    tbl[2] = '{"sat_neg", uniform_x(16'h7F00), uniform_mem(16'h8100, 16'h7F00), 0,
               uniform_lane(16'h8000)};
`endif
    tbl[3] = '{"gapped", uniform_x(16'h0100), uniform_mem(16'h0080, 16'h0100), 2,
               uniform_lane(16'h0300)};
    tbl[4] = '{"packing", uniform_x(16'h0100), uniform_mem(16'h0000, 16'h0000), 0,
               uniform_lane(16'h0000)};
    for (int a = 0; a < H; a++)
      for (int j = 0; j < N; j++) tbl[4].mem[a][j] = 16'(j * 16'h0040);
    for (int j = 0; j < N; j++) tbl[4].exp[j] = 16'(j * 16'h0100);
    // -1/256 * 0.5 = -1/512 floors to -1/256
    tbl[5] = '{"floor_neg", uniform_x(16'h0000), uniform_mem(16'h0000, 16'h0000), 0,
               uniform_lane(16'h0000)};
    tbl[5].x[0] = 16'hFFFF;
    tbl[5].mem[0][0] = 16'h0080;
`ifndef FC_NEURON_RELU_EN
    tbl[5].exp[0] = 16'hFFFF;
`endif

    // ---------------- reset ----------------
    reset_i = 1'b1; valid_i = 1'b0; data_i = '0; ready_i = 1'b0;
    mem_cur = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_data", data_o, 64'd0);
    check("rst_addr", 64'(mem_addr_o), 64'd0);
    reset_i = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(ready_o), 64'd1);

    // ---------------- table ----------------
    for (int k = 0; k < 6; k++) begin
      mem_cur = tbl[k].mem;
      run(tbl[k].x, tbl[k].gap, res, lat);
      for (int j = 0; j < N; j++)
        check({tbl[k].name, "_lane"}, 64'(res[j]), 64'(tbl[k].exp[j]));
      ack();
    end

    // ---------------- backpressure ----------------
    mem_cur = tbl[0].mem;
    run(tbl[0].x, 0, held, lat);
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 16'h1234;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); @(negedge clk);
      check("bp_valid", 64'(valid_o), 64'd1);
      check("bp_data", data_o, held);
      check("bp_ready", 64'(ready_o), 64'd0);
    end
    valid_i = 1'b0;
    ack();
    run(tbl[0].x, 0, res, lat);
    check("bp_second", res, uniform_lane(16'h0300));
    ack();

    // ---------------- reset mid-operation ----------------
    for (int i = 0; i < 2; i++) begin
      data_i = 16'h7F00; valid_i = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    valid_i = 1'b0;
    reset_i = 1'b1;
    #1;
    check("midrst_addr", 64'(mem_addr_o), 64'd0);
    check("midrst_valid", 64'(valid_o), 64'd0);
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    run(tbl[0].x, 0, res, lat);
    check("midrst_result", res, uniform_lane(16'h0300));
    // Reset while a result is presented drops valid_o at once
    reset_i = 1'b1;
    #1;
    check("donerst_valid", 64'(valid_o), 64'd0);
    check("donerst_data", data_o, 64'd0);
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    check("donerst_ready", 64'(ready_o), 64'd1);

    // ---------------- randomized against reference ----------------
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < H; i++)
        rx[i] = (it % 2 == 0) ? 16'($urandom_range(0, 4095)) - 16'd2048 : 16'($urandom);
      for (int a = 0; a <= H; a++)
        for (int j = 0; j < N; j++)
          rm[a][j] = (it % 2 == 0) ? 16'($urandom_range(0, 1023)) - 16'd512 : 16'($urandom);
      rgap = int'($urandom_range(0, 2));
      mem_cur = rm;
      run(rx, rgap, res, lat);
      for (int j = 0; j < N; j++)
        check("rand_lane", 64'(res[j]), 64'(ref_lane(rx, rm, j)));
      ack();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fc_neuron_array
`default_nettype wire
